// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the execute stage and the mul/div unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output valid, funct, a, b, flush, input ready, done, hi, lo);
  modport slave(input valid, funct, a, b, flush, output ready, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine with the HI/LO register pair
module mul_div_unit #(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           resetn,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic               is_md, is_mt, sgn, req;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [WIDTH:0]     msum, rsh, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  assign req   = bus.valid && !bus.flush && state_q == IDLE;
  assign is_md = bus.funct[5:2] == 4'b0110;
  assign is_mt = bus.funct == F_MTHI || bus.funct == F_MTLO;
  assign sgn   = !bus.funct[0];
  assign abs_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // Multiply: add the multiplicand into the upper half when the LSB is set, then shift right
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opb_q : {WIDTH{1'b0}}};
  assign mul_nxt = {msum, acc_q[WIDTH-1:1]};
  // Divide: shift left, trial-subtract the divisor, keep the difference if no borrow
  assign rsh     = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff    = rsh - {1'b0, opb_q};
  assign div_nxt = diff[WIDTH] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (req && is_md) begin
      state_d = RUN;
      cnt_d   = '0;
      div_d   = bus.funct[1];
      // A zero divisor keeps the all-ones quotient unnegated so lo reads 0xFFFFFFFF
      neg_d   = (bus.funct[1] && bus.b == '0) ? 1'b0 : sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      rneg_d  = sgn && bus.a[WIDTH-1];
      acc_d   = {{WIDTH{1'b0}}, abs_a};
      opb_d   = abs_b;
    end else if (req && is_mt) begin
      hi_d = bus.funct == F_MTHI ? bus.a : hi_q;
      lo_d = bus.funct == F_MTLO ? bus.a : lo_q;
    end else if (state_q != IDLE && bus.flush) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      acc_d   = div_q ? div_nxt : mul_nxt;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(WIDTH-1) ? FIX : RUN;
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d  = 1'b1;
      hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d    = div_q ? quo : prod[WIDTH-1:0];
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a done-driven scoreboard for mul_div_unit
module tb_mul_div_unit;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] MTHI = 6'h11, MTLO = 6'h13;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  mul_div_unit_if #(.WIDTH(32)) bus();
  mul_div_unit #(.WIDTH(32)) dut(.clk(clk), .resetn(resetn), .bus(bus));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: hi %h lo %h with no request outstanding", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hi", bus.hi, e[63:32]);
        check("lo", bus.lo, e[31:0]);
      end
    end
  end
  task automatic start(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    bus.valid = 1'b1;
    bus.funct = f;
    bus.a     = x;
    bus.b     = y;
    if (push) exp_q.push_back({eh, el});
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    int bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.done && bus.ready) bad++;
    end while (!bus.done && n < 100);
    check("latency", 64'(n - 1), 64'd33);
    check("ready_busy", 64'(bad), 64'd0);
    check("ready_done", {63'd0, bus.ready}, 64'd1);
  endtask
  task automatic op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start(f, x, y, eh, el, 1'b1);
    wait_done();
  endtask
  initial begin
    int d0;
    bus.valid = 1'b0;
    bus.funct = 6'h00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    #12;
    check("rst_hi", bus.hi, 64'd0);
    check("rst_lo", bus.lo, 64'd0);
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    op(MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    // Back-to-back: issue in the done cycle with no bubble
    start(MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
    wait_done();
    op(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    op(DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    op(DIV, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    op(DIV, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF);
    op(MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    // Preload HI/LO, then exercise ignored and blocked requests
    @(negedge clk);
    start(MTHI, 32'hAAAA5555, 32'd0, 32'd0, 32'd0, 1'b0);
    check("mthi", bus.hi, 64'hAAAA5555);
    @(negedge clk);
    start(MTLO, 32'h0000BEEF, 32'd0, 32'd0, 32'd0, 1'b0);
    check("mtlo", bus.lo, 64'h0000BEEF);
    check("mt_ready", {63'd0, bus.ready}, 64'd1);
    @(negedge clk);
    start(6'h20, 32'h11111111, 32'h22222222, 32'd0, 32'd0, 1'b0);
    check("ignored_ready", {63'd0, bus.ready}, 64'd1);
    check("ignored_lo", bus.lo, 64'h0000BEEF);
    @(negedge clk);
    bus.flush = 1'b1;
    start(MTLO, 32'h00001234, 32'd0, 32'd0, 32'd0, 1'b0);
    bus.flush = 1'b0;
    check("flush_idle_lo", bus.lo, 64'h0000BEEF);
    d0 = dones;
    @(negedge clk);
    start(MULT, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {63'd0, bus.ready}, 64'd1);
    check("flush_hi", bus.hi, 64'hAAAA5555);
    check("flush_lo", bus.lo, 64'h0000BEEF);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(dones - d0), 64'd0);
    check("flush_hi_late", bus.hi, 64'hAAAA5555);
    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start(DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("arst_hi", bus.hi, 64'd0);
    check("arst_lo", bus.lo, 64'd0);
    check("arst_ready", {63'd0, bus.ready}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start(MTLO, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    check("mtlo_after_rst", bus.lo, 64'd5);
    check("mtlo_no_done", {63'd0, bus.done}, 64'd0);
    op(DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, plus the architectural HI/LO register pair.
- Receives the operands and funct codes that the single-cycle ALU rejects (its default case).
- Sits beside the ALU in the execute stage. The pipeline stalls on ready=0. MFHI/MFLO read the hi/lo outputs directly.
- Radix-2 engine: 32 iteration cycles plus 1 sign-fixup cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- valid  input  1  request strobe. Qualified by funct.
- funct  input  6  MIPS R-type funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13. Any other value is ignored.
- a  input  WIDTH  rs value: multiplicand or dividend; the source for MTHI/MTLO.
- b  input  WIDTH  rt value: multiplier or divisor.
- flush  input  1  abandon the in-flight operation (exception or branch squash).
- ready  output  1  high when in IDLE; a request is accepted only when high.
- done  output  1  one-cycle pulse; HI/LO were updated by a mul/div at this edge.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, counter=0, hi=0, lo=0, done=0, ready=1.
  - An operation in progress is discarded.
- States:
  - IDLE: waiting for a request.
  - RUN: 32 iterations.
  - FIX: sign correction and writeback.
- Acceptance at edge E0 requires valid=1, ready=1, flush=0 and a mul/div funct:
  - Latch the op kind and signedness.
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch the result signs: product/quotient negative = a[31]^b[31]; remainder takes the sign of a.
  - Clear the counter; go to RUN.
- MTHI/MTLO accepted in IDLE:
  - Write a into hi (MTHI) or lo (MTLO) at that edge.
  - Stay in IDLE; done is not asserted.
- RUN, edges E1..E32, one iteration per edge:
  - Multiply: shift-add of the 64-bit accumulator.
  - Divide: restoring shift-subtract of the 64-bit remainder/quotient register.
  - Counter increments each edge; at counter=31 go to FIX (edge E32).
- FIX, edge E33:
  - Apply the two's-complement sign fixups.
  - Write hi/lo: mul gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
  - done=1 for exactly this cycle; state returns to IDLE, so ready=1 in the same cycle.
  - Results are visible 33 cycles after acceptance.
- Back-to-back: a new request may be accepted in the done cycle.
- valid while ready=0 is ignored; the requester holds the request until ready.
- Divide by zero (b=0), signed or unsigned: lo=0xFFFFFFFF, hi=a. Deterministic, no trap.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- flush:
  - In RUN or FIX: next state is IDLE, hi/lo unchanged, done=0.
  - flush has priority over the FIX writeback in the same cycle.
  - In IDLE: blocks acceptance of a same-cycle valid, including MTHI/MTLO.
- Arithmetic is computed at 2*WIDTH internally; no carries are lost. MULTU of all-ones operands is exact.
- resetn asserted mid-RUN: immediate return to IDLE with hi=lo=0. After release, the first request behaves as a fresh acceptance.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 33 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; ready low throughout, high in the done cycle.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU 100/7 -> lo=14, hi=2.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. The same for signed DIV.
5. Preload via MTHI 0xAAAA5555 and MTLO 0x0000BEEF; start MULT; pulse flush at cycle 10 -> no done pulse, hi/lo keep their preloaded values, ready=1 the next cycle.
6. Start DIVU, drop resetn at cycle 20 -> hi=lo=0 immediately. After release: MTLO 5 -> lo=5 next edge. Issue MULT on the done cycle of a prior op -> accepted with no bubble.
